life_led_shifter: RTL and testbench

Serial transmitter for the Game-of-Life board state. It accepts one parallel board frame through a valid/ready handshake and shifts it out MSB-first on a three-wire shift-register LED chain (data, shift clock, latch). It sits between `main` (the board generator, source of `leds_out`) and the off-chip LED driver chain, so the board can drive shift-register LEDs instead of parallel pins.

---
 rtl/life_led_shifter.sv | 176 +++++++++++++++++
 tb/tb_life_led_shifter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_led_shifter.sv
// Parallel board frame -> MSB-first serial stream on an sdata/sclk/latch LED shift-register chain.
// Optional macro LIFE_SHIFTER_SKIP_DUP_EN: frames identical to the last latched frame are consumed without shifting.
module life_led_shifter #(
  parameter int unsigned N_BITS  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BITS-1:0] frame_in,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic              sdata,
  output logic              sclk,
  output logic              latch,
  output logic              busy
);

  localparam int unsigned PH_W = $clog2(CLK_DIV + 1);
  localparam int unsigned BC_W = $clog2(N_BITS + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(N_BITS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;

  logic frame_ready_q, frame_ready_d;
  logic sdata_q, sdata_d;
  logic sclk_q, sclk_d;
  logic latch_q, latch_d;
  logic busy_q, busy_d;

  logic accept;
  logic start;
  logic dup;
  logic phase_done;

  assign accept     = frame_valid && frame_ready_q;
  assign phase_done = (phase_q == PH_LAST);
  assign start      = accept && !dup;

`ifdef LIFE_SHIFTER_SKIP_DUP_EN
  // cur_q remembers the frame in flight; last_q only takes it once LATCH completes
  logic [N_BITS-1:0] cur_q, cur_d;
  logic [N_BITS-1:0] last_q, last_d;
  logic              last_vld_q, last_vld_d;

  assign dup = last_vld_q && (frame_in == last_q);

  always_comb begin
    cur_d      = cur_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    if (start) begin
      cur_d = frame_in;
    end
    if ((state_q == LATCH) && phase_done) begin
      last_d     = cur_q;
      last_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_q      <= '0;
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT_LO;
          phase_d   = '0;
          bit_cnt_d = '0;
          shreg_d   = frame_in;
        end
      end
      SHIFT_LO: begin
        if (phase_done) begin
          state_d = SHIFT_HI;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_done) begin
          phase_d   = '0;
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          state_d   = (bit_cnt_q == BC_LAST) ? LATCH : SHIFT_LO;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      LATCH: begin
        if (phase_done) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_d        = (state_d != IDLE);
    frame_ready_d = (state_d == IDLE);
    sclk_d        = (state_d == SHIFT_HI);
    latch_d       = (state_d == LATCH);
    sdata_d       = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shreg_d[N_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q       <= '0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      frame_ready_q <= 1'b1;
      sdata_q       <= 1'b0;
      sclk_q        <= 1'b0;
      latch_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      frame_ready_q <= frame_ready_d;
      sdata_q       <= sdata_d;
      sclk_q        <= sclk_d;
      latch_q       <= latch_d;
      busy_q        <= busy_d;
    end
  end

  assign frame_ready = frame_ready_q;
  assign sdata       = sdata_q;
  assign sclk        = sclk_q;
  assign latch       = latch_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_life_led_shifter.sv
// Self-checking bench for life_led_shifter; expected waveforms come from the frame timing formulas.
// Honours LIFE_SHIFTER_SKIP_DUP_EN when the design is built with it.
module tb_life_led_shifter;

  localparam int N  = 8;
  localparam int CD = 4;
  localparam int L  = (2 * N + 1) * CD + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] frame_in = '0;
  logic         frame_valid = 1'b0;
  logic         frame_ready, sdata, sclk, latch, busy;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [N-1:0] last_sent = '0;

  life_led_shifter #(.N_BITS(N), .CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_in   (frame_in),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .sdata      (sdata),
    .sclk       (sclk),
    .latch      (latch),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] obs_vec();
    return {frame_ready, busy, sclk, sdata, latch};
  endfunction

  // Expected {frame_ready,busy,sclk,sdata,latch} d cycles after the accept edge
  function automatic logic [4:0] exp_vec(input logic [N-1:0] f, input int d);
    int   k;
    int   ph;
    logic s;
    if (d >= 1 && d <= 2 * N * CD) begin
      k = (d - 1) / (2 * CD);
      ph = (d - 1) % (2 * CD);
      s = (ph >= CD);
      return {1'b0, 1'b1, s, f[N-1-k], 1'b0};
    end else if (d >= 1 && d <= (2 * N + 1) * CD) begin
      return 5'b01001;
    end
    return 5'b10000;
  endfunction

  function automatic logic [N-1:0] fresh_frame();
    logic [N-1:0] f;
    do f = N'($urandom); while (f == last_sent || f == 8'h00 || f == 8'hFF ||
                                f == 8'h3C || f == 8'h6E);
    return f;
  endfunction

  task automatic accept_frame(input logic [N-1:0] f);
    frame_in = f;
    frame_valid = 1'b1;
    step();
    frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (obs_vec() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", obs_vec(), 5'b10000);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    checks++;
    if (obs_vec() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", obs_vec(), 5'b10000);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] f;
    logic [N-1:0] got;
    int           edges;
    logic         prev;
    f = 8'b1011_0010;
    accept_frame(f);
    got = '0;
    edges = 0;
    prev = 1'b0;
    for (int d = 1; d <= L; d++) begin
      checks++;
      if (obs_vec() !== exp_vec(f, d)) begin
        errors++;
        $display("FAIL single d=%0d got=%b exp=%b", d, obs_vec(), exp_vec(f, d));
      end
      if (sclk && !prev) begin
        got = {got[N-2:0], sdata};
        edges++;
      end
      prev = sclk;
      if (d < L) step();
    end
    checks++;
    if (edges !== N) begin
      errors++;
      $display("FAIL single_edges got=%0d exp=%0d", edges, N);
    end
    checks++;
    if (got !== f) begin
      errors++;
      $display("FAIL single_bits got=%h exp=%h", got, f);
    end
    checks++;
    if (frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready_t69 got=%b exp=1", frame_ready);
    end
    last_sent = f;
  endtask

  task automatic test_random_frames();
    logic [N-1:0] f;
    int           gap;
    for (int i = 0; i < 5; i++) begin
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        frame_in = N'($urandom);
        step();
        checks++;
        if (obs_vec() !== 5'b10000) begin
          errors++;
          $display("FAIL random_idle i=%0d got=%b exp=%b", i, obs_vec(), 5'b10000);
        end
      end
      f = fresh_frame();
      accept_frame(f);
      for (int d = 1; d <= L; d++) begin
        checks++;
        if (obs_vec() !== exp_vec(f, d)) begin
          errors++;
          $display("FAIL random f=%h d=%0d got=%b exp=%b", f, d, obs_vec(), exp_vec(f, d));
        end
        if (d < L) step();
      end
      last_sent = f;
    end
  endtask

  task automatic test_back_to_back();
    int t_a;
    int t_b;
    frame_in = 8'hFF;
    frame_valid = 1'b1;
    step();
    t_a = cyc;
    for (int d = 1; d <= L; d++) begin
      checks++;
      if (obs_vec() !== exp_vec(8'hFF, d)) begin
        errors++;
        $display("FAIL b2b_first d=%0d got=%b exp=%b", d, obs_vec(), exp_vec(8'hFF, d));
      end
      if (d < L) step();
    end
    frame_in = 8'h00;
    step();
    t_b = cyc;
    frame_valid = 1'b0;
    checks++;
    if (t_b - t_a !== 69) begin
      errors++;
      $display("FAIL b2b_spacing got=%0d exp=69", t_b - t_a);
    end
    for (int d = 1; d <= L; d++) begin
      checks++;
      if (obs_vec() !== exp_vec(8'h00, d)) begin
        errors++;
        $display("FAIL b2b_second d=%0d got=%b exp=%b", d, obs_vec(), exp_vec(8'h00, d));
      end
      if (d < L) step();
    end
    last_sent = 8'h00;
  endtask

  task automatic test_ignore_busy();
    logic [N-1:0] f;
    f = 8'h6E;
    accept_frame(f);
    for (int d = 1; d <= L; d++) begin
      checks++;
      if (obs_vec() !== exp_vec(f, d)) begin
        errors++;
        $display("FAIL ignore_busy d=%0d got=%b exp=%b", d, obs_vec(), exp_vec(f, d));
      end
      if (d < L) begin
        frame_valid = 1'($urandom_range(0, 1));
        frame_in = N'($urandom);
        step();
      end
    end
    frame_valid = 1'b0;
    last_sent = f;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] f;
    f = 8'hA5;
    accept_frame(f);
    for (int d = 1; d <= 26; d++) begin
      checks++;
      if (obs_vec() !== exp_vec(f, d)) begin
        errors++;
        $display("FAIL reset_mid_pre d=%0d got=%b exp=%b", d, obs_vec(), exp_vec(f, d));
      end
      if (d < 26) step();
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid_async got=%b exp=%b", obs_vec(), 5'b10000);
    end
    repeat (2) step();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      step();
      checks++;
      if (obs_vec() !== 5'b10000) begin
        errors++;
        $display("FAIL reset_mid_idle i=%0d got=%b exp=%b", i, obs_vec(), 5'b10000);
      end
    end
    accept_frame(f);
    for (int d = 1; d <= L; d++) begin
      checks++;
      if (obs_vec() !== exp_vec(f, d)) begin
        errors++;
        $display("FAIL reset_mid_next d=%0d got=%b exp=%b", d, obs_vec(), exp_vec(f, d));
      end
      if (d < L) step();
    end
    last_sent = f;
  endtask

  task automatic test_repeat_frame();
    logic [N-1:0] seq [3];
    logic [4:0]   e;
    seq[0] = 8'h3C;
    seq[1] = 8'h3C;
    seq[2] = 8'h3D;
    for (int i = 0; i < 3; i++) begin
      accept_frame(seq[i]);
      for (int d = 1; d <= L; d++) begin
        e = exp_vec(seq[i], d);
`ifdef LIFE_SHIFTER_SKIP_DUP_EN
        if (i == 1) e = 5'b10000;
`endif
        checks++;
        if (obs_vec() !== e) begin
          errors++;
          $display("FAIL repeat i=%0d d=%0d got=%b exp=%b", i, d, obs_vec(), e);
        end
        if (d < L) step();
      end
    end
    last_sent = 8'h3D;
  endtask

  initial begin
    test_reset();
    test_single();
    test_random_frames();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_repeat_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
